axi_lite_cmd_master: RTL and testbench
======================================

Name: axi_lite_cmd_master

Overview:
- AXI4-Lite single-beat master that converts one-cycle write/read command pulses from local logic into AXI write (AW/W/B) and read (AR/R) transactions.
- Returns the read data, the response status and a one-cycle done pulse.
- Sits between a local controller and an AXI-Lite slave bridge that fronts the register file. One transaction is outstanding at a time.

Parameters:
- AW, 32, address width of addr/awaddr/araddr.
- DW, 32, data width of w_data/wdata/rdata/r_data.

Ports:
- clk input 1: single clock, all logic on rising edge.
- rstn input 1: synchronous, active-low reset.
- addr input AW: command address, sampled with wcmd/rcmd.
- w_data input DW: write data, sampled with wcmd.
- wcmd input 1: one-cycle write command pulse.
- rcmd input 1: one-cycle read command pulse.
- r_data output DW: last read data captured.
- done output 1: one-cycle pulse at transaction completion.
- rw_status output 2: BRESP/RRESP of last completed transaction.
- awvalid output 1, awready input 1, awaddr output AW: write address channel.
- wvalid output 1, wready input 1, wdata output DW: write data channel.
- bvalid input 1, bready output 1, bresp input 2: write response channel.
- arvalid output 1, arready input 1, araddr output AW: read address channel.
- rvalid input 1, rready output 1, rdata input DW, rresp input 2: read data channel.

Behaviour:
- All outputs are registered.
- Reset (rstn=0 at a clock edge) forces the following to 0: every valid/ready output, done, rw_status, r_data, awaddr, araddr, wdata. The FSM goes to IDLE.
- Reset mid-transaction abandons the transaction; no done is generated.
- FSM states are IDLE, WR_REQ, WR_RESP, RD_REQ and RD_DATA.
- IDLE + wcmd:
  - Latch addr into awaddr and w_data into wdata.
  - Assert awvalid and wvalid from the next cycle.
  - Go to WR_REQ.
- IDLE + rcmd (without wcmd):
  - Latch addr into araddr.
  - Assert arvalid from the next cycle.
  - Go to RD_REQ.
- wcmd and rcmd in the same cycle: the write wins and the read is dropped.
- Commands arriving outside IDLE are ignored. addr/w_data are don't-care outside command cycles.
- WR_REQ:
  - awvalid drops the cycle after awvalid&awready.
  - wvalid drops the cycle after wvalid&wready.
  - The AW and W handshakes are independent and may complete in either order or together.
  - When both have completed, assert bready and go to WR_RESP.
- WR_RESP:
  - On bvalid&bready: rw_status<=bresp, bready<=0, done<=1 for one cycle, return to IDLE.
- RD_REQ:
  - On arvalid&arready: arvalid<=0, rready<=1, go to RD_DATA.
- RD_DATA:
  - On rvalid&rready: r_data<=rdata, rw_status<=rresp, rready<=0, done<=1 for one cycle, return to IDLE.
- Valid signals never drop before their handshake (AXI rule).
- awaddr, wdata and araddr stay stable while the corresponding valid is high, and hold their value afterwards.
- Minimum write latency with an always-ready slave: wcmd at edge 0 → AW/W valid cycle 1 → bready cycle 2 → done cycle 3 or later, depending on slave bvalid. Reads have the same latency profile.
- A new command is accepted in the cycle done is high, because the FSM is already in IDLE.
- r_data and rw_status hold their values until the next completion. A write does not change r_data.
- Responses are not interpreted; SLVERR/DECERR are passed through on rw_status with done still pulsed.

Test Plan:
- Reset check: hold rstn=0 for 2 cycles → all valids/readies, done, rw_status and r_data are 0. Toggling wcmd during reset has no effect.
- Write, slave responds OKAY: wcmd with addr=0x0000_0100, w_data=0x3456_789A.
  - awaddr=0x100 and wdata=0x3456_789A are presented with valids held until ready.
  - Single done pulse, rw_status=2'b00.
- Read, slave responds OKAY: rcmd with addr=0x0000_0100, slave returns 0x3456_789A/OKAY → araddr=0x100, r_data=0x3456_789A, rw_status=00, single done pulse.
- Decoupled handshakes:
  - Slave raises wready 3 cycles before awready → wvalid drops first, awvalid stays high until awready.
  - bready rises only after both handshakes; a single done pulse follows.
- Error response and ignored commands:
  - Write to 0x0000_0080 with bresp=2'b10 → rw_status=2'b10, done pulses.
  - A rcmd issued during the write is ignored, with no AR activity.
- Collision and reset: wcmd and rcmd in the same cycle → only the write occurs. Asserting rstn=0 while waiting for rvalid → outputs return to 0 and no done is generated.

Source files
------------

// File: rtl/axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_cmd_master
// Description : AXI4-Lite single-beat master. Converts one-cycle write/read
//               command pulses from local logic into AXI write (AW/W/B) and
//               read (AR/R) transactions, one outstanding at a time. Returns
//               the read data, the response status and a one-cycle done pulse.
// Ports       : clk, rstn           - clock, synchronous active-low reset
//               addr, w_data        - command address / write data
//               wcmd, rcmd          - one-cycle command pulses
//               r_data, rw_status   - last read data / last BRESP or RRESP
//               done                - one-cycle completion pulse
//               aw*/w*/b*/ar*/r*    - AXI4-Lite master channels
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_cmd_master #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    // local command interface
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] w_data,
    input  logic          wcmd,
    input  logic          rcmd,
    output logic [DW-1:0] r_data,
    output logic          done,
    output logic [1:0]    rw_status,
    // write address channel
    output logic          awvalid,
    input  logic          awready,
    output logic [AW-1:0] awaddr,
    // write data channel
    output logic          wvalid,
    input  logic          wready,
    output logic [DW-1:0] wdata,
    // write response channel
    input  logic          bvalid,
    output logic          bready,
    input  logic [1:0]    bresp,
    // read address channel
    output logic          arvalid,
    input  logic          arready,
    output logic [AW-1:0] araddr,
    // read data channel
    input  logic          rvalid,
    output logic          rready,
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    rresp
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;

    logic [2:0]    r_state;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_arvalid;
    logic          r_rready;
    logic          r_done;
    logic [1:0]    r_rw_status;
    logic [DW-1:0] r_r_data;
    logic [AW-1:0] r_awaddr;
    logic [DW-1:0] r_wdata;
    logic [AW-1:0] r_araddr;

    // A write channel counts as finished once its valid is already low or
    // its handshake completes in this cycle; AW and W may finish in either
    // order, so the move to the response phase waits for both.
    logic w_aw_clear;
    logic w_w_clear;

    assign w_aw_clear = !r_awvalid || awready;
    assign w_w_clear  = !r_wvalid  || wready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_done      <= 1'b0;
            r_rw_status <= 2'b00;
            r_r_data    <= '0;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_araddr    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Write has priority when both pulses arrive together.
                    if (wcmd) begin
                        r_awaddr  <= addr;
                        r_wdata   <= w_data;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_WR_REQ;
                    end else if (rcmd) begin
                        r_araddr  <= addr;
                        r_arvalid <= 1'b1;
                        r_state   <= S_RD_REQ;
                    end
                end
                S_WR_REQ: begin
                    if (r_awvalid && awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_clear && w_w_clear) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bvalid && r_bready) begin
                        r_rw_status <= bresp;
                        r_bready    <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                S_RD_REQ: begin
                    if (r_arvalid && arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rvalid && r_rready) begin
                        r_r_data    <= rdata;
                        r_rw_status <= rresp;
                        r_rready    <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign awvalid   = r_awvalid;
    assign wvalid    = r_wvalid;
    assign bready    = r_bready;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign done      = r_done;
    assign rw_status = r_rw_status;
    assign r_data    = r_r_data;
    assign awaddr    = r_awaddr;
    assign wdata     = r_wdata;
    assign araddr    = r_araddr;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_cmd_master
// Description : Self-checking bench for axi_lite_cmd_master. A behavioural
//               AXI-Lite slave with programmable per-channel ready/valid
//               delays answers the master; expected completions are queued
//               when commands are issued and compared on each done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] w_data = '0;
    logic          wcmd = 1'b0;
    logic          rcmd = 1'b0;
    logic [DW-1:0] r_data;
    logic          done;
    logic [1:0]    rw_status;
    logic          awvalid;
    logic          awready = 1'b0;
    logic [AW-1:0] awaddr;
    logic          wvalid;
    logic          wready = 1'b0;
    logic [DW-1:0] wdata;
    logic          bvalid = 1'b0;
    logic          bready;
    logic [1:0]    bresp = 2'b00;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [AW-1:0] araddr;
    logic          rvalid = 1'b0;
    logic          rready;
    logic [DW-1:0] rdata = '0;
    logic [1:0]    rresp = 2'b00;

    axi_lite_cmd_master #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn),
        .addr(addr), .w_data(w_data), .wcmd(wcmd), .rcmd(rcmd),
        .r_data(r_data), .done(done), .rw_status(rw_status),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    // ---------------- slave configuration and observation ----------------
    int            aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0]    bresp_val = 2'b00, rresp_val = 2'b00;
    logic [DW-1:0] rdata_val = '0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
    int aw_hs_cyc = 0, w_hs_cyc = 0, cyc = 0;
    int done_cnt = 0, ar_seen = 0, overlap = 0, early_drop = 0;
    logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;

    // Slave acts on the falling edge so its readies/valids are stable for
    // the next rising edge; a valid&ready pair seen here completes there.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid))
                early_drop++;
            if (!awvalid || awready) begin awready = 1'b0; aw_cnt = 0; end
            else if (aw_cnt >= aw_delay) awready = 1'b1;
            else aw_cnt++;
            if (!wvalid || wready) begin wready = 1'b0; w_cnt = 0; end
            else if (w_cnt >= w_delay) wready = 1'b1;
            else w_cnt++;
            if (!arvalid || arready) begin arready = 1'b0; ar_cnt = 0; end
            else if (ar_cnt >= ar_delay) arready = 1'b1;
            else ar_cnt++;
            if (!bready || bvalid) begin bvalid = 1'b0; bresp = 2'b00; b_cnt = 0; end
            else if (b_cnt >= b_delay) begin bvalid = 1'b1; bresp = bresp_val; end
            else b_cnt++;
            if (!rready || rvalid) begin rvalid = 1'b0; rdata = '0; rresp = 2'b00; r_cnt = 0; end
            else if (r_cnt >= r_delay) begin rvalid = 1'b1; rdata = rdata_val; rresp = rresp_val; end
            else r_cnt++;
            if (awvalid && awready) begin aw_hs++; cap_awaddr = awaddr; aw_hs_cyc = cyc; end
            if (wvalid && wready) begin w_hs++; cap_wdata = wdata; w_hs_cyc = cyc; end
            if (arvalid && arready) begin ar_hs++; cap_araddr = araddr; end
            if (bvalid && bready) b_hs++;
            if (rvalid && rready) r_hs++;
            aw_pend = awvalid && !awready;
            w_pend  = wvalid && !wready;
            ar_pend = arvalid && !arready;
            if (bready && (awvalid || wvalid)) overlap++;
            if (arvalid) ar_seen++;
            if (done) done_cnt++;
        end
    end

    // ---------------- checking infrastructure ----------------
    typedef struct {
        logic [DW-1:0] data;
        logic [1:0]    resp;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_rdata = '0;
    int            errors = 0;
    int            checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valids"}, {60'd0, awvalid, wvalid, arvalid, done}, 64'd0);
        check({tag, "_readies"}, {62'd0, bready, rready}, 64'd0);
        check({tag, "_status"}, {62'd0, rw_status}, 64'd0);
        check({tag, "_rdata"}, {32'd0, r_data}, 64'd0);
        check({tag, "_addrs"}, {awaddr, araddr}, 64'd0);
        check({tag, "_wdata"}, {32'd0, wdata}, 64'd0);
    endtask

    task automatic issue(input logic w, input logic r, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [1:0] exp_resp,
                         input logic [DW-1:0] exp_rd);
        exp_t e;
        e.data = w ? model_rdata : exp_rd;
        e.resp = exp_resp;
        if (!w) model_rdata = exp_rd;
        sb.push_back(e);
        addr = a; w_data = d; wcmd = w; rcmd = r;
        step();
        wcmd = 1'b0; rcmd = 1'b0; addr = '0; w_data = '0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        int   n;
        exp_t e;
        n = 0;
        while (!done && n < max_cyc) begin step(); n++; end
        check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
        if (done) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check({tag, "_r_data"}, {32'd0, r_data}, {32'd0, e.data});
                check({tag, "_rw_status"}, {62'd0, rw_status}, {62'd0, e.resp});
            end
            step();
            check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int base_aw, base_ar, base_done;

        // Reset with wcmd toggling: nothing must start.
        rstn = 1'b0; wcmd = 1'b1; addr = 32'h0000_0055; w_data = 32'hFFFF_FFFF;
        step();
        wcmd = 1'b0;
        step();
        wcmd = 1'b1;
        step();
        check_idle_outputs("reset");
        rstn = 1'b1; wcmd = 1'b0; addr = '0; w_data = '0;
        step(); step(); step();
        check("reset_no_aw", aw_hs, 0);
        check_idle_outputs("post_reset");

        // Write OKAY.
        aw_delay = 1; w_delay = 1; b_delay = 1; bresp_val = 2'b00;
        issue(1'b1, 1'b0, 32'h0000_0100, 32'h3456_789A, 2'b00, '0);
        wait_done("wr_ok", 40);
        check("wr_ok_awaddr", cap_awaddr, 32'h0000_0100);
        check("wr_ok_wdata", cap_wdata, 32'h3456_789A);
        check("wr_ok_hs", {aw_hs, w_hs}, {32'd1, 32'd1});
        check("wr_ok_bhs", b_hs, 1);

        // Read OKAY.
        ar_delay = 2; r_delay = 1; rdata_val = 32'h3456_789A; rresp_val = 2'b00;
        issue(1'b0, 1'b1, 32'h0000_0100, '0, 2'b00, 32'h3456_789A);
        wait_done("rd_ok", 40);
        check("rd_ok_araddr", cap_araddr, 32'h0000_0100);
        check("rd_ok_rhs", {ar_hs, r_hs}, {32'd1, 32'd1});

        // Decoupled handshakes: W completes three cycles before AW.
        aw_delay = 3; w_delay = 0; b_delay = 0;
        issue(1'b1, 1'b0, 32'h0000_0104, 32'hA5A5_0001, 2'b00, '0);
        wait_done("wr_dec", 40);
        check("wr_dec_order", aw_hs_cyc - w_hs_cyc, 3);
        check("wr_dec_awaddr", cap_awaddr, 32'h0000_0104);
        check("wr_dec_wdata", cap_wdata, 32'hA5A5_0001);
        check("wr_dec_bready_overlap", overlap, 0);

        // SLVERR write with an ignored read command during it.
        aw_delay = 0; w_delay = 2; b_delay = 3; bresp_val = 2'b10;
        base_ar = ar_seen;
        issue(1'b1, 1'b0, 32'h0000_0080, 32'h0BAD_CAFE, 2'b10, '0);
        step();
        issue(1'b0, 1'b1, 32'h0000_0300, '0, 2'b00, '0);
        void'(sb.pop_back());
        model_rdata = 32'h3456_789A;
        wait_done("wr_err", 40);
        check("wr_err_awaddr", cap_awaddr, 32'h0000_0080);
        step(); step();
        check("wr_err_no_ar", ar_seen - base_ar, 0);

        // Collision: write wins, read dropped.
        aw_delay = 0; w_delay = 0; b_delay = 0; bresp_val = 2'b00;
        base_ar = ar_seen; base_aw = aw_hs;
        issue(1'b1, 1'b1, 32'h0000_0200, 32'h0000_0011, 2'b00, '0);
        wait_done("coll", 40);
        step(); step();
        check("coll_aw_once", aw_hs - base_aw, 1);
        check("coll_no_ar", ar_seen - base_ar, 0);
        check("coll_wdata", cap_wdata, 32'h0000_0011);

        // Reset while waiting for rvalid: abandoned, no done.
        ar_delay = 0; r_delay = 20; rdata_val = 32'hDEAD_BEEF;
        issue(1'b0, 1'b1, 32'h0000_0044, '0, 2'b00, 32'hDEAD_BEEF);
        for (int i = 0; i < 10 && !rready; i++) step();
        check("rst_mid_rready", {63'd0, rready}, 64'd1);
        base_done = done_cnt;
        rstn = 1'b0;
        step();
        check_idle_outputs("rst_mid");
        rstn = 1'b1;
        sb.delete();
        model_rdata = '0;
        for (int i = 0; i < 30; i++) step();
        check("rst_mid_no_done", done_cnt - base_done, 0);
        check("rst_mid_quiet", {62'd0, arvalid, rready}, 64'd0);

        // Read after reset with DECERR passed through.
        r_delay = 0; rdata_val = 32'hCAFE_F00D; rresp_val = 2'b11;
        issue(1'b0, 1'b1, 32'h0000_0040, '0, 2'b11, 32'hCAFE_F00D);
        wait_done("rd_dec", 40);
        check("rd_dec_araddr", cap_araddr, 32'h0000_0040);

        check("no_early_valid_drop", early_drop, 0);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
